fft_frame_sched: RTL and testbench

- Top-level frame sequencer for the streaming FFT path. Each frame passes through three phases: receive (AXI-S slave interface fills the sample memory), compute (FFT core, in place), transmit (AXI-S master interface drains the memory).
- Grants sample-memory ownership to exactly one agent at a time.
- Drives the comp_busy and m_axis_if_busy inputs of the slave interface, so it admits a new frame only when the memory is free.
- Checks frame length and per-phase watchdogs, and reports errors.

---
 rtl/fft_frame_sched.sv | 201 ++++++++++++++++++++
 tb/tb_fft_frame_sched.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_sched.sv
// Frame sequencer for the streaming FFT path: receive -> compute -> transmit,
// with single-owner sample memory arbitration, length check and per-phase watchdog.
module fft_frame_sched #(
    parameter int C_FFT_SIZE_LOG2 = 10,
    parameter int TIMEOUT_WDT     = 16,
    parameter int FRAME_CNT_WDT   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [TIMEOUT_WDT-1:0]   timeout_lim,
    input  logic                     s_axis_if_busy,
    input  logic                     push,
    input  logic                     rx_done,
    output logic                     comp_busy,
    output logic                     m_axis_if_busy,
    output logic                     fft_start,
    input  logic                     fft_done,
    output logic                     tx_start,
    input  logic                     tx_done,
    output logic [1:0]               mem_owner,
    output logic [FRAME_CNT_WDT-1:0] frame_cnt,
    output logic                     err_len,
    output logic                     err_timeout,
    input  logic                     err_clr,
    output logic [2:0]               sched_state
);

    localparam int PCW = C_FFT_SIZE_LOG2 + 1;
    localparam logic [PCW-1:0] FRAME_LEN = {1'b1, {C_FFT_SIZE_LOG2{1'b0}}};
    localparam logic [PCW-1:0] PUSH_MAX  = '1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RX     = 3'd1,
        S_CSTART = 3'd2,
        S_COMP   = 3'd3,
        S_TSTART = 3'd4,
        S_TX     = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_RX   = 2'd1,
        OWN_FFT  = 2'd2,
        OWN_TX   = 2'd3
    } owner_t;

    state_t                   state_q, state_d;
    logic [PCW-1:0]           push_cnt_q, push_cnt_d;
    logic [TIMEOUT_WDT-1:0]   wdt_q, wdt_d;
    logic [FRAME_CNT_WDT-1:0] frame_cnt_q, frame_cnt_d;
    logic                     err_len_q, err_len_d;
    logic                     err_to_q, err_to_d;
    logic                     comp_busy_q, comp_busy_d;
    logic                     m_busy_q, m_busy_d;
    logic                     fft_start_q, fft_start_d;
    logic                     tx_start_q, tx_start_d;
    owner_t                   owner_q, owner_d;

    logic [PCW-1:0] push_total;
    logic           wdt_expire;
    logic           set_len;
    logic           set_to;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d     = state_q;
        push_cnt_d  = push_cnt_q;
        wdt_d       = wdt_q;
        frame_cnt_d = frame_cnt_q;
        set_len     = 1'b0;
        set_to      = 1'b0;
        comp_busy_d = 1'b1;
        m_busy_d    = 1'b0;
        fft_start_d = 1'b0;
        tx_start_d  = 1'b0;
        owner_d     = OWN_NONE;

        // A push coinciding with rx_done is part of the frame being closed.
        push_total = (push && (push_cnt_q != PUSH_MAX)) ? push_cnt_q + PCW'(1) : push_cnt_q;
        wdt_expire = (timeout_lim != '0) && (wdt_q == timeout_lim - TIMEOUT_WDT'(1));

        case (state_q)
            S_IDLE: begin
                if (enable && s_axis_if_busy) state_d = S_RX;
            end
            S_RX: begin
                push_cnt_d = push_total;
                if (rx_done) begin
                    if (push_total == FRAME_LEN) begin
                        state_d = S_CSTART;
                    end else begin
                        set_len = 1'b1;
                        state_d = S_IDLE;
                    end
                end else if (wdt_expire) begin
                    set_to  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_CSTART: state_d = S_COMP;
            S_COMP: begin
                if (fft_done) begin
                    state_d = S_TSTART;
                end else if (wdt_expire) begin
                    set_to  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_TSTART: state_d = S_TX;
            S_TX: begin
                if (tx_done) begin
                    frame_cnt_d = frame_cnt_q + FRAME_CNT_WDT'(1);
                    state_d     = S_IDLE;
                end else if (wdt_expire) begin
                    set_to  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d != state_q) begin
            wdt_d = '0;
        end else if (state_q == S_RX || state_q == S_COMP || state_q == S_TX) begin
            wdt_d = wdt_q + TIMEOUT_WDT'(1);
        end
        if (state_d != S_RX) push_cnt_d = '0;

        // A fresh error event outranks a simultaneous clear.
        err_len_d = set_len | (err_len_q & ~err_clr);
        err_to_d  = set_to  | (err_to_q  & ~err_clr);

        // Outputs are decoded from the next state so they register alongside it.
        case (state_d)
            S_IDLE:   comp_busy_d = ~enable;
            S_RX: begin
                comp_busy_d = 1'b0;
                owner_d     = OWN_RX;
            end
            S_CSTART: begin
                fft_start_d = 1'b1;
                owner_d     = OWN_FFT;
            end
            S_COMP:   owner_d = OWN_FFT;
            S_TSTART: begin
                tx_start_d  = 1'b1;
                owner_d     = OWN_TX;
                m_busy_d    = 1'b1;
                comp_busy_d = 1'b0;
            end
            S_TX: begin
                owner_d     = OWN_TX;
                m_busy_d    = 1'b1;
                comp_busy_d = 1'b0;
            end
            default: comp_busy_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state_q     <= S_IDLE;
            push_cnt_q  <= '0;
            wdt_q       <= '0;
            frame_cnt_q <= '0;
            err_len_q   <= 1'b0;
            err_to_q    <= 1'b0;
            comp_busy_q <= 1'b1;
            m_busy_q    <= 1'b0;
            fft_start_q <= 1'b0;
            tx_start_q  <= 1'b0;
            owner_q     <= OWN_NONE;
        end else begin
            state_q     <= state_d;
            push_cnt_q  <= push_cnt_d;
            wdt_q       <= wdt_d;
            frame_cnt_q <= frame_cnt_d;
            err_len_q   <= err_len_d;
            err_to_q    <= err_to_d;
            comp_busy_q <= comp_busy_d;
            m_busy_q    <= m_busy_d;
            fft_start_q <= fft_start_d;
            tx_start_q  <= tx_start_d;
            owner_q     <= owner_d;
        end
    end

    assign comp_busy      = comp_busy_q;
    assign m_axis_if_busy = m_busy_q;
    assign fft_start      = fft_start_q;
    assign tx_start       = tx_start_q;
    assign mem_owner      = owner_q;
    assign frame_cnt      = frame_cnt_q;
    assign err_len        = err_len_q;
    assign err_timeout    = err_to_q;
    assign sched_state    = state_q;

endmodule

// File: tb/tb_fft_frame_sched.sv
// Self-checking bench for fft_frame_sched: table of frame scenarios, hand-written
// reset/enable sequences, and random frames checked against a frame-level model.
module tb_fft_frame_sched;

    localparam int N = 1024;
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RX   = 3'd1;
    localparam logic [2:0] ST_COMP = 3'd3;
    localparam logic [2:0] ST_TX   = 3'd5;
    localparam int PHASE_BUDGET = 2000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] timeout_lim = '0;
    logic        s_axis_if_busy = 1'b0;
    logic        push = 1'b0;
    logic        rx_done = 1'b0;
    logic        comp_busy;
    logic        m_axis_if_busy;
    logic        fft_start;
    logic        fft_done = 1'b0;
    logic        tx_start;
    logic        tx_done = 1'b0;
    logic [1:0]  mem_owner;
    logic [15:0] frame_cnt;
    logic        err_len;
    logic        err_timeout;
    logic        err_clr = 1'b0;
    logic [2:0]  sched_state;

    int n_checks = 0;
    int n_errors = 0;
    int exp_frame_cnt = 0;

    fft_frame_sched #(
        .C_FFT_SIZE_LOG2(10),
        .TIMEOUT_WDT    (16),
        .FRAME_CNT_WDT  (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .timeout_lim   (timeout_lim),
        .s_axis_if_busy(s_axis_if_busy),
        .push          (push),
        .rx_done       (rx_done),
        .comp_busy     (comp_busy),
        .m_axis_if_busy(m_axis_if_busy),
        .fft_start     (fft_start),
        .fft_done      (fft_done),
        .tx_start      (tx_start),
        .tx_done       (tx_done),
        .mem_owner     (mem_owner),
        .frame_cnt     (frame_cnt),
        .err_len       (err_len),
        .err_timeout   (err_timeout),
        .err_clr       (err_clr),
        .sched_state   (sched_state)
    );

    always #5 clk = ~clk;

    // Stimulus plus expected outcome of one frame.
    typedef struct {
        string name;
        int    n_push;
        bit    same;
        int    gap_pct;
        int    comp_d;
        int    tx_d;
        int    lim;
        bit    drop_en;
        bit    e_fft;
        bit    e_len;
        bit    e_to;
        int    e_comp;
        int    e_tx;
        bit    e_done;
    } frame_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string nm);
        int n = 0;
        while (sched_state != s && n < budget) begin
            tick();
            n++;
        end
        check(nm, int'(sched_state), int'(s));
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_state"},       int'(sched_state), 0);
        check({tag, "_comp_busy"},   int'(comp_busy), 1);
        check({tag, "_m_busy"},      int'(m_axis_if_busy), 0);
        check({tag, "_fft_start"},   int'(fft_start), 0);
        check({tag, "_tx_start"},    int'(tx_start), 0);
        check({tag, "_mem_owner"},   int'(mem_owner), 0);
        check({tag, "_frame_cnt"},   int'(frame_cnt), 0);
        check({tag, "_err_len"},     int'(err_len), 0);
        check({tag, "_err_timeout"}, int'(err_timeout), 0);
    endtask

    // Frame-level reference: outcome follows from length and phase delays vs. the limit.
    function automatic frame_t model(input frame_t f);
        frame_t r = f;
        bit comp_to, tx_to;
        r.e_fft  = (f.n_push == N);
        r.e_len  = !r.e_fft;
        comp_to  = r.e_fft && f.lim != 0 && f.comp_d >= f.lim;
        tx_to    = r.e_fft && !comp_to && f.lim != 0 && f.tx_d >= f.lim;
        r.e_comp = !r.e_fft ? 0 : (comp_to ? f.lim : f.comp_d + 1);
        r.e_tx   = (!r.e_fft || comp_to) ? 0 : (tx_to ? f.lim : f.tx_d + 1);
        r.e_to   = comp_to || tx_to;
        r.e_done = r.e_fft && !r.e_to;
        return r;
    endfunction

    task automatic rx_phase(input int n, input bit same, input int gap);
        s_axis_if_busy = 1'b1;
        wait_state(ST_RX, 10, "enter_rx");
        s_axis_if_busy = 1'b0;
        check("rx_owner", int'(mem_owner), 1);
        for (int i = 0; i < n; i++) begin
            if (gap > 0 && $urandom_range(99) < gap) begin
                push = 1'b0;
                tick();
            end
            push    = 1'b1;
            rx_done = same && (i == n - 1);
            tick();
        end
        push = 1'b0;
        if (!same) begin
            rx_done = 1'b1;
            tick();
        end
        rx_done = 1'b0;
    endtask

    task automatic clear_errors(input string nm);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check({nm, "_clr_len"}, int'(err_len), 0);
        check({nm, "_clr_to"},  int'(err_timeout), 0);
    endtask

    task automatic run_frame(input frame_t f);
        int idx;
        enable      = 1'b1;
        timeout_lim = '0;
        rx_phase(f.n_push, f.same, f.gap_pct);
        // Sampled one cycle after rx_done.
        check({f.name, "_fft_start"}, int'(fft_start), int'(f.e_fft));
        check({f.name, "_err_len"},   int'(err_len),   int'(f.e_len));
        if (!f.e_fft) begin
            check({f.name, "_len_idle"},  int'(sched_state), int'(ST_IDLE));
            check({f.name, "_len_owner"}, int'(mem_owner), 0);
            check({f.name, "_len_cnt"},   int'(frame_cnt), exp_frame_cnt);
            clear_errors(f.name);
            return;
        end
        check({f.name, "_cstart_owner"}, int'(mem_owner), 2);
        check({f.name, "_cstart_busy"},  int'(comp_busy), 1);
        timeout_lim = 16'(f.lim);
        if (f.drop_en) enable = 1'b0;
        tick();
        check({f.name, "_fft_start_pulse"}, int'(fft_start), 0);

        idx = 0;
        while (sched_state == ST_COMP && idx < PHASE_BUDGET) begin
            fft_done = (idx == f.comp_d);
            tick();
            fft_done = 1'b0;
            idx++;
        end
        check({f.name, "_comp_cycles"}, idx, f.e_comp);
        if (f.e_to && f.e_tx == 0) begin
            check({f.name, "_comp_to_flag"},  int'(err_timeout), 1);
            check({f.name, "_comp_to_owner"}, int'(mem_owner), 0);
            check({f.name, "_comp_to_idle"},  int'(sched_state), int'(ST_IDLE));
            clear_errors(f.name);
            timeout_lim = '0;
            return;
        end
        check({f.name, "_tx_start"},  int'(tx_start), 1);
        check({f.name, "_tx_owner"},  int'(mem_owner), 3);
        check({f.name, "_tx_m_busy"}, int'(m_axis_if_busy), 1);
        tick();

        idx = 0;
        while (sched_state == ST_TX && idx < PHASE_BUDGET) begin
            tx_done = (idx == f.tx_d);
            tick();
            tx_done = 1'b0;
            idx++;
        end
        check({f.name, "_tx_cycles"}, idx, f.e_tx);
        if (f.e_done) exp_frame_cnt++;
        check({f.name, "_frame_cnt"},   int'(frame_cnt), exp_frame_cnt);
        check({f.name, "_err_timeout"}, int'(err_timeout), int'(f.e_to));
        check({f.name, "_end_idle"},    int'(sched_state), int'(ST_IDLE));
        check({f.name, "_end_owner"},   int'(mem_owner), 0);
        if (f.e_to) clear_errors(f.name);
        timeout_lim = '0;

        if (f.drop_en) begin
            s_axis_if_busy = 1'b1;
            repeat (5) tick();
            check({f.name, "_hold_idle"}, int'(sched_state), int'(ST_IDLE));
            check({f.name, "_hold_busy"}, int'(comp_busy), 1);
            s_axis_if_busy = 1'b0;
            enable = 1'b1;
            tick();
        end
    endtask

    initial begin
        frame_t tbl[10];
        tbl[0] = '{"nominal",   1024, 0,  0,    5,  7,   0, 0, 1, 0, 0,   6,  8, 1};
        tbl[1] = '{"short",     1000, 0,  0,    0,  0,   0, 0, 0, 1, 0,   0,  0, 0};
        tbl[2] = '{"same_cyc",  1024, 1,  0,    0,  0,   0, 0, 1, 0, 0,   1,  1, 1};
        tbl[3] = '{"long",      1030, 0, 20,    0,  0,   0, 0, 0, 1, 0,   0,  0, 0};
        tbl[4] = '{"comp_wdt",  1024, 0,  0, 5000,  0, 100, 0, 1, 0, 1, 100,  0, 0};
        tbl[5] = '{"exit_wins", 1024, 0,  0,   99,  3, 100, 0, 1, 0, 0, 100,  4, 1};
        tbl[6] = '{"no_wdt",    1024, 0,  0,  300,  2,   0, 0, 1, 0, 0, 301,  3, 1};
        tbl[7] = '{"tx_wdt",    1024, 1, 10,   10, 60,  50, 0, 1, 0, 1,  11, 50, 0};
        tbl[8] = '{"lim_one",   1024, 0,  0,    0,  0,   1, 0, 1, 0, 0,   1,  1, 1};
        tbl[9] = '{"drop_en",   1024, 0,  0,   20,  5,   0, 1, 1, 0, 0,  21,  6, 1};

        tick();
        tick();
        check_reset("reset");
        rst = 1'b0;

        // Enable gating: admission refused while enable is low.
        tick();
        check("gate_busy0", int'(comp_busy), 1);
        s_axis_if_busy = 1'b1;
        repeat (4) tick();
        check("gate_idle", int'(sched_state), int'(ST_IDLE));
        check("gate_busy", int'(comp_busy), 1);
        s_axis_if_busy = 1'b0;
        enable = 1'b1;
        tick();
        check("gate_release", int'(comp_busy), 0);

        // Stray completion pulses in IDLE are ignored.
        fft_done = 1'b1;
        tx_done  = 1'b1;
        rx_done  = 1'b1;
        tick();
        fft_done = 1'b0;
        tx_done  = 1'b0;
        rx_done  = 1'b0;
        tick();
        check("stray_idle", int'(sched_state), int'(ST_IDLE));
        check("stray_cnt",  int'(frame_cnt), 0);

        for (int i = 0; i < 10; i++) run_frame(tbl[i]);

        // Reset while transmitting, then a clean frame.
        enable = 1'b1;
        rx_phase(N, 1'b0, 0);
        wait_state(ST_COMP, 5, "rst_seq_comp");
        fft_done = 1'b1;
        tick();
        fft_done = 1'b0;
        wait_state(ST_TX, 5, "rst_seq_tx");
        tick();
        rst = 1'b1;
        tick();
        check_reset("rst_tx");
        rst = 1'b0;
        exp_frame_cnt = 0;
        run_frame(tbl[0]);
        check("rst_then_frame", int'(frame_cnt), 1);

        for (int r = 0; r < 8; r++) begin
            frame_t f;
            int pick;
            f.name = $sformatf("rand%0d", r);
            pick = int'($urandom_range(5));
            case (pick)
                0, 1, 2: f.n_push = N;
                3:       f.n_push = N - 1;
                4:       f.n_push = N + 1;
                default: f.n_push = int'($urandom_range(1040, 1000));
            endcase
            f.same    = ($urandom_range(1) == 1);
            f.gap_pct = int'($urandom_range(30));
            f.comp_d  = int'($urandom_range(120));
            f.tx_d    = int'($urandom_range(120));
            f.lim     = ($urandom_range(3) == 0) ? 0 : int'($urandom_range(100, 1));
            f.drop_en = 1'b0;
            run_frame(model(f));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
